sprite_loader: RTL and testbench

Buffers sprite position/attribute update commands from the host and replays them to the sprite bank only while the display is in vertical blank, so sprite moves never tear mid-frame. Sits directly upstream of the per-sprite engines: it drives their shared `x`/`y`/`visible` buses and a one-hot `load_pos`/`load_att` strobe per sprite.

---
 rtl/sprite_pkg.sv | 30 +++
 rtl/sprite_cmd_fifo.sv | 79 +++++++
 rtl/sprite_loader.sv | 203 ++++++++++++++++++++
 tb/tb_sprite_loader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg
//   Shared constants and types for the sprite command loader:
//   command type codes, field widths, the packed command entry stored
//   in the FIFO, and the drain FSM state encoding.
package sprite_pkg;

  localparam logic CMD_POS = 1'b0;
  localparam logic CMD_ATT = 1'b1;

  localparam int SPR_X_W   = 10;
  localparam int SPR_Y_W   = 9;
  localparam int SPR_SEL_W = 4;

  // One queued host command, exactly as it will be replayed to the bank.
  typedef struct packed {
    logic [SPR_SEL_W-1:0] sel;
    logic                 typ;
    logic [SPR_X_W-1:0]   x;
    logic [SPR_Y_W-1:0]   y;
    logic                 vis;
  } sprite_cmd_t;

  localparam int CMD_W = $bits(sprite_cmd_t);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } drain_state_t;

endpackage

// File: rtl/sprite_cmd_fifo.sv
// sprite_cmd_fifo
//   Synchronous FIFO holding host commands until vertical blank.
//   Head data is presented combinationally; a pop simply advances the
//   read pointer.
// Ports:
//   clk, rst       clock, synchronous active-high reset (empties FIFO)
//   push, wdata    write request and data (ignored when full)
//   pop            read request (ignored when empty)
//   rdata          current head entry
//   full, empty    status flags
//   count          occupancy, 0..DEPTH
module sprite_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify requests against the flags so the pointers can never wrap past each other.
  always_comb begin
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Status and head-of-queue view.
  always_comb begin
    rdata = mem_r[rd_ptr_r];
    full  = (count_r == CNT_W'(DEPTH));
    empty = (count_r == CNT_W'(0));
    count = count_r;
  end

endmodule

// File: rtl/sprite_loader.sv
// sprite_loader
//   Queues sprite position/attribute commands from the host and replays
//   them to the sprite engines only during vertical blank, one per cycle,
//   so on-screen sprites never change mid-frame.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       host handshake, transfer when both high
//   cmd_sel, cmd_type         target sprite and command kind (POS/ATT)
//   cmd_x, cmd_y, cmd_vis     command payload
//   vblank                    vertical blank indicator
//   load_pos, load_att        one-hot per-sprite load strobes (registered)
//   x, y, visible             shared payload buses (registered, held)
//   pending                   FIFO occupancy
//   err_sel                   sticky flag: out-of-range sprite index drained
module sprite_loader
  import sprite_pkg::*;
#(
  parameter int N_SPRITES = 8,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [SPR_SEL_W-1:0]   cmd_sel,
  input  logic                   cmd_type,
  input  logic [SPR_X_W-1:0]     cmd_x,
  input  logic [SPR_Y_W-1:0]     cmd_y,
  input  logic                   cmd_vis,
  input  logic                   vblank,
  output logic [N_SPRITES-1:0]   load_pos,
  output logic [N_SPRITES-1:0]   load_att,
  output logic [SPR_X_W-1:0]     x,
  output logic [SPR_Y_W-1:0]     y,
  output logic                   visible,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   err_sel
);

  // Compare sel against the sprite count with one spare bit so N_SPRITES=16 fits.
  localparam logic [SPR_SEL_W:0] SEL_LIMIT = (SPR_SEL_W + 1)'(N_SPRITES);

  drain_state_t          state_r;
  drain_state_t          state_next_s;

  sprite_cmd_t           push_entry_s;
  sprite_cmd_t           head_s;
  logic [CMD_W-1:0]      head_data_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  sel_ok_s;
  logic [N_SPRITES-1:0]  sel_oh_s;
  logic [N_SPRITES-1:0]  pos_next_s;
  logic [N_SPRITES-1:0]  att_next_s;

  logic [N_SPRITES-1:0]  load_pos_r;
  logic [N_SPRITES-1:0]  load_att_r;
  logic [SPR_X_W-1:0]    x_r;
  logic [SPR_Y_W-1:0]    y_r;
  logic                  visible_r;
  logic                  err_sel_r;

  // Decode a sprite index into a one-hot lane mask.
  function automatic logic [N_SPRITES-1:0] sel_onehot(input logic [SPR_SEL_W-1:0] sel);
    logic [N_SPRITES-1:0] oh;
    oh = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      if (sel == SPR_SEL_W'(i)) begin
        oh[i] = 1'b1;
      end else begin
        oh[i] = 1'b0;
      end
    end
    return oh;
  endfunction

  // Pack the host command into a FIFO entry and qualify the handshake.
  always_comb begin
    push_entry_s.sel = cmd_sel;
    push_entry_s.typ = cmd_type;
    push_entry_s.x   = cmd_x;
    push_entry_s.y   = cmd_y;
    push_entry_s.vis = cmd_vis;
    cmd_ready        = !fifo_full_s;
    push_s           = cmd_valid && !fifo_full_s;
  end

  sprite_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (push_entry_s),
    .pop   (pop_s),
    .rdata (head_data_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (pending)
  );

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Drain FSM next-state: drain while in blank with work queued.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (vblank && !fifo_empty_s) begin
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!vblank || fifo_empty_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Drain FSM outputs: the edge that enters ISSUE already pops, so both
  // states pop under the same condition; an IDLE-with-blank cycle must not
  // add a bubble or the accept-to-strobe latency would grow.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      ST_IDLE:  pop_s = vblank && !fifo_empty_s;
      ST_ISSUE: pop_s = vblank && !fifo_empty_s;
      default:  pop_s = 1'b0;
    endcase
  end

  // Head-entry decode into next-cycle strobe values.
  always_comb begin
    head_s     = head_data_s;
    sel_ok_s   = ({1'b0, head_s.sel} < SEL_LIMIT);
    sel_oh_s   = sel_onehot(head_s.sel);
    pos_next_s = '0;
    att_next_s = '0;
    if (pop_s && sel_ok_s) begin
      case (head_s.typ)
        CMD_POS: pos_next_s = sel_oh_s;
        CMD_ATT: att_next_s = sel_oh_s;
        default: begin
          pos_next_s = '0;
          att_next_s = '0;
        end
      endcase
    end else begin
      pos_next_s = '0;
      att_next_s = '0;
    end
  end

  // Registered sprite-bus outputs; payload holds between issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_pos_r <= '0;
      load_att_r <= '0;
      x_r        <= '0;
      y_r        <= '0;
      visible_r  <= 1'b0;
      err_sel_r  <= 1'b0;
    end else begin
      load_pos_r <= pos_next_s;
      load_att_r <= att_next_s;
      if (pop_s) begin
        x_r       <= head_s.x;
        y_r       <= head_s.y;
        visible_r <= head_s.vis;
        if (!sel_ok_s) begin
          err_sel_r <= 1'b1;
        end
      end
    end
  end

  // Drive ports from the output registers.
  always_comb begin
    load_pos = load_pos_r;
    load_att = load_att_r;
    x        = x_r;
    y        = y_r;
    visible  = visible_r;
    err_sel  = err_sel_r;
  end

endmodule

// File: tb/tb_sprite_loader.sv
// tb_sprite_loader
//   Directed plus randomized bench for sprite_loader. A queue-based
//   reference model predicts occupancy, strobes and bus values each cycle.
module tb_sprite_loader;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_sel;
  logic         cmd_type;
  logic [9:0]   cmd_x;
  logic [8:0]   cmd_y;
  logic         cmd_vis;
  logic         vblank;
  logic [N-1:0] load_pos;
  logic [N-1:0] load_att;
  logic [9:0]   x;
  logic [8:0]   y;
  logic         visible;
  logic [2:0]   pending;
  logic         err_sel;

  always #5 clk = ~clk;

  sprite_loader #(.N_SPRITES(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_sel   (cmd_sel),
    .cmd_type  (cmd_type),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_vis   (cmd_vis),
    .vblank    (vblank),
    .load_pos  (load_pos),
    .load_att  (load_att),
    .x         (x),
    .y         (y),
    .visible   (visible),
    .pending   (pending),
    .err_sel   (err_sel)
  );

  typedef struct {
    logic [3:0] sel;
    logic       typ;
    logic [9:0] x;
    logic [8:0] y;
    logic       vis;
  } cmd_t;

  cmd_t         q[$];
  logic [N-1:0] exp_lp;
  logic [N-1:0] exp_la;
  logic [9:0]   exp_x;
  logic [8:0]   exp_y;
  logic         exp_vis;
  logic         exp_err;
  int           tests = 0;
  int           fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic step(input logic v, input logic [3:0] s, input logic t,
                      input logic [9:0] xx, input logic [8:0] yy, input logic vs,
                      input logic vb, input logic r);
    cmd_t e;
    bit   do_pop;
    bit   do_push;
    cmd_valid = v; cmd_sel = s; cmd_type = t; cmd_x = xx; cmd_y = yy;
    cmd_vis = vs; vblank = vb; rst = r;
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_lp = '0; exp_la = '0; exp_x = '0; exp_y = '0; exp_vis = 1'b0; exp_err = 1'b0;
    end else begin
      do_pop  = vb && (q.size() > 0);
      do_push = v && (q.size() < DEPTH);
      exp_lp  = '0;
      exp_la  = '0;
      if (do_pop) begin
        e       = q.pop_front();
        exp_x   = e.x;
        exp_y   = e.y;
        exp_vis = e.vis;
        if (e.sel < 4'd8) begin
          if (e.typ) exp_la[e.sel[2:0]] = 1'b1;
          else       exp_lp[e.sel[2:0]] = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
      end
      if (do_push) begin
        e.sel = s; e.typ = t; e.x = xx; e.y = yy; e.vis = vs;
        q.push_back(e);
      end
    end
    #1;
    chk("load_pos",  32'(load_pos),  32'(exp_lp));
    chk("load_att",  32'(load_att),  32'(exp_la));
    chk("x",         32'(x),         32'(exp_x));
    chk("y",         32'(y),         32'(exp_y));
    chk("visible",   32'(visible),   32'(exp_vis));
    chk("err_sel",   32'(err_sel),   32'(exp_err));
    chk("pending",   32'(pending),   32'(q.size()));
    chk("cmd_ready", 32'(cmd_ready), 32'(q.size() < DEPTH));
  endtask

  task automatic idle(input logic vb, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 10'd0, 9'd0, 1'b0, vb, 1'b0);
  endtask

  initial begin
    logic       rv, rt, rvis, rvb, rr;
    logic [3:0] rs;
    logic [9:0] rx;
    logic [8:0] ry;

    // Reset
    step(1'b0, 4'd0, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1);
    chk("reset_ready", 32'(cmd_ready), 32'd1);
    chk("reset_pending", 32'(pending), 32'd0);

    // POS command with blank already active: strobe two edges after accept
    step(1'b1, 4'd3, 1'b0, 10'h0C8, 9'h064, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 1);
    chk("pos_strobe", 32'(load_pos), 32'h08);
    chk("pos_x", 32'(x), 32'h0C8);
    chk("pos_y", 32'(y), 32'h064);
    idle(1'b1, 1);
    chk("pos_one_cycle", 32'(load_pos), 32'h00);

    // ATT command
    step(1'b1, 4'd0, 1'b1, 10'd1, 9'd0, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1);
    chk("att_strobe", 32'(load_att), 32'h01);
    chk("att_vis", 32'(visible), 32'd1);
    idle(1'b1, 2);

    // Fill outside blank, then drain in one burst
    for (int i = 0; i < 4; i++)
      step(1'b1, 4'(i + 1), 1'(i & 1), 10'(i * 40 + 7), 9'(i * 9 + 3), 1'(i & 1), 1'b0, 1'b0);
    chk("full_pending", 32'(pending), 32'd4);
    chk("full_ready", 32'(cmd_ready), 32'd0);
    idle(1'b1, 5);
    chk("drained", 32'(pending), 32'd0);

    // Blank only two cycles: two issues, two left for the next blank
    for (int i = 0; i < 4; i++)
      step(1'b1, 4'(7 - i), 1'b0, 10'(i + 100), 9'(i + 50), 1'b0, 1'b0, 1'b0);
    idle(1'b1, 2);
    idle(1'b0, 3);
    chk("partial_pending", 32'(pending), 32'd2);
    idle(1'b1, 3);

    // Out-of-range sprite index sets a sticky error
    step(1'b1, 4'd9, 1'b0, 10'h155, 9'h0AA, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 1);
    chk("bad_sel_no_strobe", 32'(load_pos | load_att), 32'd0);
    chk("bad_sel_err", 32'(err_sel), 32'd1);
    step(1'b1, 4'd2, 1'b1, 10'd0, 9'd1, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 2);
    chk("err_sticky", 32'(err_sel), 32'd1);

    // Reset mid-drain discards queued entries
    for (int i = 0; i < 4; i++)
      step(1'b1, 4'(i), 1'b0, 10'(i + 1), 9'(i + 2), 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1);
    step(1'b0, 4'd0, 1'b0, 10'd0, 9'd0, 1'b0, 1'b1, 1'b1);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_err", 32'(err_sel), 32'd0);
    idle(1'b1, 4);

    // Randomized traffic
    rvb = 1'b0;
    for (int i = 0; i < 600; i++) begin
      rv   = 1'($urandom_range(0, 1));
      rs   = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      rt   = 1'($urandom_range(0, 1));
      rx   = 10'($urandom);
      ry   = 9'($urandom);
      rvis = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) rvb = ~rvb;
      rr   = ($urandom_range(0, 199) == 0);
      step(rv, rs, rt, rx, ry, rvis, rvb, rr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
